// File: rtl/keyboard_renderer.sv
// On-screen keyboard renderer: redraws each key rectangle on the 160x120 VGA adapter port whenever its pressed state changes.
// Define KEYBOARD_RENDERER_OUTLINE_EN to draw a black one-pixel outline around every key.
module keyboard_renderer #(
    parameter int         NUM_KEYS   = 4,
    parameter int         KEY_W      = 16,
    parameter int         KEY_H      = 40,
    parameter int         GAP        = 2,
    parameter int         X0         = 8,
    parameter int         Y0         = 40,
    parameter logic [2:0] ON_COLOUR  = 3'b010,
    parameter logic [2:0] OFF_COLOUR = 3'b111
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [2:0]          colour,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic                plot
);

    localparam int SEL_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int COL_W = $clog2(KEY_W);
    localparam int ROW_W = $clog2(KEY_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(KEY_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(KEY_H - 1);
    localparam logic [7:0]       X0_B     = 8'(X0);
    localparam logic [7:0]       PITCH_B  = 8'(KEY_W + GAP);
    localparam logic [6:0]       Y0_B     = 7'(Y0);

    typedef enum logic {
        IDLE,
        DRAW
    } state_t;

    state_t state, state_d;

    logic [NUM_KEYS-1:0] keys_meta, keys_s;
    logic [NUM_KEYS-1:0] drawn, drawn_d;
    logic [NUM_KEYS-1:0] dirty, dirty_d;
    logic [NUM_KEYS-1:0] pending;
    logic [SEL_W-1:0]    sel, sel_d, pick;
    logic                val, val_d;
    logic [COL_W-1:0]    col, col_d;
    logic [ROW_W-1:0]    row, row_d;
    logic [2:0]          colour_d;
    logic [7:0]          x_d;
    logic [6:0]          y_d;
    logic                plot_d;

    // Two-flop synchroniser for the asynchronous key inputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            keys_meta <= '0;
            keys_s    <= '0;
        end else begin
            keys_meta <= keys;
            keys_s    <= keys_meta;
        end
    end

    assign pending = dirty | (keys_s ^ drawn);

    // Lowest pending index wins
    always_comb begin
        pick = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state;
        sel_d   = sel;
        val_d   = val;
        col_d   = col;
        row_d   = row;
        drawn_d = drawn;
        dirty_d = dirty;
        case (state)
            IDLE: begin
                if (|pending) begin
                    sel_d        = pick;
                    val_d        = keys_s[pick];
                    drawn_d[pick] = keys_s[pick];
                    dirty_d[pick] = 1'b0;
                    col_d        = '0;
                    row_d        = '0;
                    state_d      = DRAW;
                end
            end
            DRAW: begin
                if (col == COL_LAST) begin
                    col_d = '0;
                    if (row == ROW_LAST) begin
                        state_d = IDLE;
                    end else begin
                        row_d = row + 1'b1;
                    end
                end else begin
                    col_d = col + 1'b1;
                end
            end
        endcase
    end

    // Outputs are registered from the next-state pixel so plot is high exactly while in DRAW
    always_comb begin
        plot_d   = (state_d == DRAW);
        colour_d = colour;
        x_d      = x;
        y_d      = y;
        if (plot_d) begin
            x_d      = X0_B + 8'(sel_d) * PITCH_B + 8'(col_d);
            y_d      = Y0_B + 7'(row_d);
            colour_d = val_d ? ON_COLOUR : OFF_COLOUR;
`ifdef KEYBOARD_RENDERER_OUTLINE_EN
            if ((row_d == '0) || (row_d == ROW_LAST) || (col_d == '0) || (col_d == COL_LAST)) begin
                colour_d = 3'b000;
            end
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sel    <= '0;
            val    <= 1'b0;
            col    <= '0;
            row    <= '0;
            drawn  <= '0;
            dirty  <= '1;
            plot   <= 1'b0;
            colour <= 3'b000;
            x      <= 8'd0;
            y      <= 7'd0;
        end else begin
            state  <= state_d;
            sel    <= sel_d;
            val    <= val_d;
            col    <= col_d;
            row    <= row_d;
            drawn  <= drawn_d;
            dirty  <= dirty_d;
            plot   <= plot_d;
            colour <= colour_d;
            x      <= x_d;
            y      <= y_d;
        end
    end

endmodule

// File: tb/tb_keyboard_renderer.sv
// Self-checking bench for keyboard_renderer: expected bursts derived from key-change rules, random key patterns.
module tb_keyboard_renderer;

    localparam int         NK     = 4;
    localparam int         KW     = 16;
    localparam int         KH     = 40;
    localparam int         GP     = 2;
    localparam int         XS     = 8;
    localparam int         YS     = 40;
    localparam logic [2:0] ON_C   = 3'b010;
    localparam logic [2:0] OFF_C  = 3'b111;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] keys  = '0;
    logic [2:0]    colour;
    logic [7:0]    x;
    logic [6:0]    y;
    logic          plot;

    int n_tests = 0;
    int n_fail  = 0;

    keyboard_renderer #(
        .NUM_KEYS(NK), .KEY_W(KW), .KEY_H(KH), .GAP(GP), .X0(XS), .Y0(YS),
        .ON_COLOUR(ON_C), .OFF_COLOUR(OFF_C)
    ) dut (
        .clock (clock),
        .reset (reset),
        .keys  (keys),
        .colour(colour),
        .x     (x),
        .y     (y),
        .plot  (plot)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_colour(input bit on, input int r, input int c);
        logic [2:0] fill;
        fill = on ? ON_C : OFF_C;
`ifdef KEYBOARD_RENDERER_OUTLINE_EN
        if (r == 0 || r == KH - 1 || c == 0 || c == KW - 1) fill = 3'b000;
`endif
        return fill;
    endfunction

    function automatic int pix(input logic p, input logic [2:0] c, input int xx, input int yy);
        logic [7:0] xb;
        logic [6:0] yb;
        xb = xx[7:0];
        yb = yy[6:0];
        return int'({p, c, xb, yb});
    endfunction

    // Waits (bounded) for a burst, checks the delay, every pixel in raster order and the trailing idle cycle.
    task automatic burst(input int k, input bit on, input int gap_exp, input int chg_at, input logic [NK-1:0] chg_val);
        int n;
        n = 0;
        while (plot !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("delay_key%0d", k), n, gap_exp);
        for (int r = 0; r < KH; r++) begin
            for (int c = 0; c < KW; c++) begin
                if (r * KW + c == chg_at) keys = chg_val;
                check($sformatf("pix_k%0d_r%0d_c%0d", k, r, c),
                      pix(plot, colour, int'(x), int'(y)),
                      pix(1'b1, exp_colour(on, r, c), XS + k * (KW + GP) + c, YS + r));
                @(negedge clock);
            end
        end
        check($sformatf("end_key%0d", k), int'(plot), 0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int hi;
        hi = 0;
        repeat (cycles) begin
            @(negedge clock);
            hi += int'(plot);
        end
        check(tag, hi, 0);
    endtask

    task automatic initial_draw();
        for (int k = 0; k < NK; k++) burst(k, 1'b0, 1, -1, '0);
        quiet("quiet_after_init", 20);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NK-1:0] cur, nv;
        bit first;

        #1;
        check("rst_plot", int'(plot), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        initial_draw();

        keys = 4'b0100;
        burst(2, 1'b1, 3, -1, '0);
        keys = 4'b0000;
        burst(2, 1'b0, 3, -1, '0);

        keys = 4'b1001;
        burst(0, 1'b1, 3, -1, '0);
        burst(3, 1'b1, 1, -1, '0);
        keys = 4'b0000;
        burst(0, 1'b0, 3, -1, '0);
        burst(3, 1'b0, 1, -1, '0);

        keys = 4'b0010;
        burst(1, 1'b1, 3, 100, 4'b0000);
        burst(1, 1'b0, 1, -1, '0);
        quiet("quiet_after_toggle", 10);

        // Abort a burst with reset at pixel 300
        keys = 4'b0001;
        begin
            int n;
            n = 0;
            while (plot !== 1'b1 && n < 60) begin
                @(negedge clock);
                n++;
            end
            check("delay_rst_burst", n, 3);
        end
        repeat (300) @(negedge clock);
        check("pre_rst_plot", int'(plot), 1);
        reset = 1'b1;
        keys  = 4'b0000;
        #1;
        check("rst_async_plot", int'(plot), 0);
        repeat (2) @(negedge clock);
        check("rst_hold_plot", int'(plot), 0);
        reset = 1'b0;
        initial_draw();

        cur = '0;
        repeat (10) begin
            nv = NK'($urandom_range(0, (1 << NK) - 1));
            keys = nv;
            first = 1'b1;
            for (int i = 0; i < NK; i++) begin
                if (nv[i] != cur[i]) begin
                    burst(i, nv[i], first ? 3 : 1, -1, '0);
                    first = 1'b0;
                end
            end
            quiet("quiet_random", 6);
            cur = nv;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
